// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative shift-add multiplier
// and the EX/MEM (M) pipeline latch with valid/flush/stall handling.
module execute_stage_mc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_flush,
  input  logic              mem_stall,
  input  logic [3:0]        alu_op,
  input  logic [1:0]        a_sel,
  input  logic [1:0]        b_sel,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] dest_ex,
  input  logic [CTRL_W-1:0] ctrl_ex,
  output logic              ex_stall,
  output logic              m_valid,
  output logic [DATA_W-1:0] alu_result_m,
  output logic [3:0]        flags_m,
  output logic [DATA_W-1:0] store_m,
  output logic [DATA_W-1:0] pc_m,
  output logic [ADDR_W-1:0] dest_m,
  output logic [CTRL_W-1:0] ctrl_m
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOTA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_INC  = 4'd9;
  localparam logic [3:0] OP_DEC  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  typedef enum logic [1:0] {M_HOLD, M_BUBBLE, M_ALU, M_MUL} mctl_t;

  state_t state, state_next;
  mctl_t  m_ctl;
  logic   mul_start;

  logic [DATA_W-1:0]   op_a, b_fwd, op_b, arith_b;
  logic [DATA_W:0]     add_w, sub_w;
  logic [DATA_W-1:0]   res;
  logic                c_flag, v_flag;
  logic [3:0]          alu_flags;

  logic [DATA_W-1:0]   mul_a, mul_store;
  logic [2*DATA_W-1:0] prod, prod_next;
  logic [DATA_W:0]     step_sum;
  logic [CNT_W-1:0]    cnt;

  // Forwarding muxes; b_fwd is the store value, so imm never reaches store_m
  always_comb begin
    unique case (a_sel)
      2'd1:    op_a = alu_result_m;
      2'd2:    op_a = wb_data;
      default: op_a = data1;
    endcase
    unique case (b_sel)
      2'd1:    b_fwd = alu_result_m;
      2'd2:    b_fwd = wb_data;
      default: b_fwd = data2;
    endcase
    op_b = (b_sel == 2'd3) ? imm : b_fwd;
  end

  assign arith_b = ((alu_op == OP_INC) || (alu_op == OP_DEC)) ? DATA_W'(1) : op_b;
  assign add_w   = {1'b0, op_a} + {1'b0, arith_b};
  assign sub_w   = {1'b0, op_a} - {1'b0, arith_b};

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (alu_op)
      OP_ADD, OP_INC: begin
        res    = add_w[DATA_W-1:0];
        c_flag = add_w[DATA_W];
        v_flag = (op_a[DATA_W-1] == arith_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SUB, OP_DEC: begin
        res    = sub_w[DATA_W-1:0];
        c_flag = ~sub_w[DATA_W];
        v_flag = (op_a[DATA_W-1] != arith_b[DATA_W-1]) && (res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_AND:  res = op_a & op_b;
      OP_OR:   res = op_a | op_b;
      OP_XOR:  res = op_a ^ op_b;
      OP_NOTA: res = ~op_a;
      OP_SHL: begin
        res    = {op_a[DATA_W-2:0], 1'b0};
        c_flag = op_a[DATA_W-1];
      end
      OP_SHR: begin
        res    = {1'b0, op_a[DATA_W-1:1]};
        c_flag = op_a[0];
      end
      OP_MUL:  res = '0;
      default: res = op_b;
    endcase
  end

  assign alu_flags = {v_flag, c_flag, res[DATA_W-1], res == '0};

  // One shift-add step: conditionally add A into the high half, then shift right
  assign step_sum  = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, (prod[0] ? mul_a : '0)};
  assign prod_next = {step_sum, prod[DATA_W-1:1]};

  assign mul_start = (state == S_IDLE) && ex_valid && (alu_op == OP_MUL) && !ex_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (mul_start && !mem_stall) state_next = S_MUL;
      S_MUL: begin
        if (ex_flush)                        state_next = S_IDLE;
        else if (cnt == CNT_W'(DATA_W - 1))  state_next = S_DONE;
      end
      S_DONE: if (ex_flush || !mem_stall) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ex_stall = mem_stall || mul_start || (state == S_MUL);
    m_ctl    = M_HOLD;
    if (!mem_stall) begin
      if ((state == S_MUL) || mul_start)  m_ctl = M_BUBBLE;
      else if (state == S_DONE)           m_ctl = ex_flush ? M_BUBBLE : M_MUL;
      else if (ex_flush || !ex_valid)     m_ctl = M_BUBBLE;
      else                                m_ctl = M_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a     <= '0;
      mul_store <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else begin
      if ((state == S_IDLE) && (state_next == S_MUL)) begin
        mul_a     <= op_a;
        mul_store <= b_fwd;
        prod      <= {{DATA_W{1'b0}}, op_b};
      end else if (state == S_MUL) begin
        prod <= prod_next;
      end
      if ((state == S_MUL) && (state_next == S_MUL)) cnt <= cnt + CNT_W'(1);
      else                                          cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid      <= 1'b0;
      alu_result_m <= '0;
      flags_m      <= '0;
      store_m      <= '0;
      pc_m         <= '0;
      dest_m       <= '0;
      ctrl_m       <= '0;
    end else begin
      unique case (m_ctl)
        M_BUBBLE: begin
          m_valid <= 1'b0;
          ctrl_m  <= '0;
        end
        M_ALU: begin
          m_valid      <= 1'b1;
          alu_result_m <= res;
          flags_m      <= alu_flags;
          store_m      <= b_fwd;
          pc_m         <= pc;
          dest_m       <= dest_ex;
          ctrl_m       <= ctrl_ex;
        end
        M_MUL: begin
          m_valid      <= 1'b1;
          alu_result_m <= prod[DATA_W-1:0];
          flags_m      <= {|prod[2*DATA_W-1:DATA_W], 1'b0, prod[DATA_W-1], prod[DATA_W-1:0] == '0};
          store_m      <= mul_store;
          pc_m         <= pc;
          dest_m       <= dest_ex;
          ctrl_m       <= ctrl_ex;
        end
        default: ;
      endcase
    end
  end

endmodule
